// File: rtl/bp_be_fe_queue_rollback_fifo.sv
// Front-end queue with speculative read, commit and replay pointers.
// Entries stay resident until committed so the back end can rewind and reissue them.
module bp_be_fe_queue_rollback_fifo #(
    parameter int unsigned width_p = 64,
    parameter int unsigned els_p   = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] fe_queue_i,
    input  logic               fe_queue_v_i,
    output logic               fe_queue_ready_o,
    output logic [width_p-1:0] fe_queue_o,
    output logic               fe_queue_v_o,
    input  logic               fe_queue_yumi_i,
    input  logic               deq_i,
    input  logic               roll_i,
    input  logic               clr_i,
    output logic               empty_o
);

    localparam int unsigned idx_w = $clog2(els_p);
    localparam int unsigned ptr_w = idx_w + 1;

    logic [width_p-1:0] mem_q [els_p];
    logic [ptr_w-1:0]   wptr_q, wptr_d;
    logic [ptr_w-1:0]   rptr_q, rptr_d;
    logic [ptr_w-1:0]   cptr_q, cptr_d;
    logic [ptr_w-1:0]   cptr_next;
    logic               full;
    logic               enq;
    logic               yumi;

    // Full when write and commit share an index but differ in wrap bit
    assign full = (wptr_q[idx_w-1:0] == cptr_q[idx_w-1:0]) & (wptr_q[idx_w] != cptr_q[idx_w]);

    assign fe_queue_ready_o = ~full;
    assign fe_queue_v_o     = (rptr_q != wptr_q);
    assign empty_o          = (wptr_q == cptr_q);
    assign fe_queue_o       = mem_q[rptr_q[idx_w-1:0]];

    assign enq       = fe_queue_v_i & ~full & ~clr_i;
    assign yumi      = fe_queue_yumi_i & fe_queue_v_o & ~roll_i & ~clr_i;
    assign cptr_next = cptr_q + ptr_w'(deq_i);

    // Pointer next-state: clear beats roll; commit always advances
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cptr_d = cptr_next;
        if (clr_i) begin
            wptr_d = cptr_next;
            rptr_d = cptr_next;
        end else begin
            if (enq) begin
                wptr_d = wptr_q + ptr_w'(1);
            end
            if (roll_i) begin
                rptr_d = cptr_next;
            end else if (yumi) begin
                rptr_d = rptr_q + ptr_w'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cptr_q <= cptr_d;
        end
    end

    // Storage is not reset; only the pointers define which entries are live
    always_ff @(posedge clk_i) begin
        if (!reset_i && enq) begin
            mem_q[wptr_q[idx_w-1:0]] <= fe_queue_i;
        end
    end

endmodule

// File: tb/tb_bp_be_fe_queue_rollback_fifo.sv
// Bench for the rollback fifo: directed scenarios plus random traffic,
// checked against a queue-based model of uncommitted entries.
module tb_bp_be_fe_queue_rollback_fifo;

    localparam int unsigned W   = 64;
    localparam int unsigned ELS = 4;

    logic         clk = 1'b0;
    logic         reset_i = 1'b0;
    logic [W-1:0] fe_queue_i = '0;
    logic         fe_queue_v_i = 1'b0;
    logic         fe_queue_ready_o;
    logic [W-1:0] fe_queue_o;
    logic         fe_queue_v_o;
    logic         fe_queue_yumi_i = 1'b0;
    logic         deq_i = 1'b0;
    logic         roll_i = 1'b0;
    logic         clr_i = 1'b0;
    logic         empty_o;

    int total = 0;
    int bad   = 0;

    // Model: uncommitted entries oldest-first; rd = how many of them are issued
    logic [W-1:0] mq[$];
    int           rd = 0;

    always #5 clk = ~clk;

    bp_be_fe_queue_rollback_fifo #(.width_p(W), .els_p(ELS)) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .fe_queue_i      (fe_queue_i),
        .fe_queue_v_i    (fe_queue_v_i),
        .fe_queue_ready_o(fe_queue_ready_o),
        .fe_queue_o      (fe_queue_o),
        .fe_queue_v_o    (fe_queue_v_o),
        .fe_queue_yumi_i (fe_queue_yumi_i),
        .deq_i           (deq_i),
        .roll_i          (roll_i),
        .clr_i           (clr_i),
        .empty_o         (empty_o)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ready"}, W'(fe_queue_ready_o), W'(mq.size() < ELS));
        chk({tag, ".v"},     W'(fe_queue_v_o),     W'(rd < mq.size()));
        chk({tag, ".empty"}, W'(empty_o),          W'(mq.size() == 0));
        if (rd < mq.size()) chk({tag, ".data"}, fe_queue_o, mq[rd]);
    endtask

    // One clock: drive, update model from pre-edge state, sample after the edge
    task automatic step(input string tag, input logic v, input logic [W-1:0] d,
                        input logic y, input logic dq, input logic rl,
                        input logic cl, input logic rs);
        bit pre_ready, pre_v;
        fe_queue_v_i = v; fe_queue_i = d; fe_queue_yumi_i = y;
        deq_i = dq; roll_i = rl; clr_i = cl; reset_i = rs;
        pre_ready = (mq.size() < ELS);
        pre_v     = (rd < mq.size());
        if (!rs && dq && rd == 0) begin
            total++; bad++;
            $error("FAIL %s.deq_illegal observed=rd0 expected=rd>0", tag);
        end
        @(posedge clk);
        if (rs) begin
            mq.delete(); rd = 0;
        end else begin
            if (dq && mq.size() > 0) begin
                void'(mq.pop_front());
                if (rd > 0) rd--;
            end
            if (cl) begin
                mq.delete(); rd = 0;
            end else begin
                if (rl) rd = 0;
                else if (y && pre_v) rd++;
                if (v && pre_ready) mq.push_back(d);
            end
        end
        #1;
        fe_queue_v_i = 1'b0; fe_queue_yumi_i = 1'b0; deq_i = 1'b0;
        roll_i = 1'b0; clr_i = 1'b0; reset_i = 1'b0;
        check_all(tag);
    endtask

    initial begin
        logic [W-1:0] d;
        bit v, y, dq, rl, cl;

        // Reset state
        step("rst", 0, '0, 0, 0, 0, 0, 1);
        chk("rst.ready_const", W'(fe_queue_ready_o), W'(1));
        chk("rst.empty_const", W'(empty_o), W'(1));

        // Fill to full, fifth dropped, drain in order
        for (int i = 0; i < 4; i++) step("fill", 1, W'(8'hA0 + i), 0, 0, 0, 0, 0);
        chk("fill.full_ready", W'(fe_queue_ready_o), W'(0));
        step("drop5", 1, W'(8'hA4), 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("drain.data", fe_queue_o, W'(8'hA0 + i));
            step("drain", 0, '0, 1, 0, 0, 0, 0);
        end

        // Issue two, commit one, replay -> B1 again
        step("rst2", 0, '0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("b_fill", 1, W'(8'hB0 + i), 0, 0, 0, 0, 0);
        step("b_yumi", 0, '0, 1, 0, 0, 0, 0);
        step("b_yumi", 0, '0, 1, 0, 0, 0, 0);
        step("b_deq", 0, '0, 0, 1, 0, 0, 0);
        step("b_roll", 0, '0, 0, 0, 1, 0, 0);
        chk("roll.data", fe_queue_o, W'(8'hB1));
        chk("roll.v", W'(fe_queue_v_o), W'(1));

        // Clear with same-cycle enqueue
        step("rst3", 0, '0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("c_fill", 1, W'(8'hC0 + i), 0, 0, 0, 0, 0);
        step("c_yumi", 0, '0, 1, 0, 0, 0, 0);
        step("c_clr", 1, W'(8'hC9), 0, 0, 0, 1, 0);
        chk("clr.v", W'(fe_queue_v_o), W'(0));
        chk("clr.empty", W'(empty_o), W'(1));

        // Full, all issued, deq with enqueue: enqueue rejected
        step("rst4", 0, '0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step("d_fill", 1, W'(8'hD0 + i), 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("d_yumi", 0, '0, 1, 0, 0, 0, 0);
        step("d_deqenq", 1, W'(8'hDE), 0, 1, 0, 0, 0);
        chk("deqenq.ready", W'(fe_queue_ready_o), W'(1));
        chk("deqenq.v", W'(fe_queue_v_o), W'(0));

        // Steady triplets across pointer wrap
        step("rst5", 0, '0, 0, 0, 0, 0, 1);
        step("t_pre", 1, W'(16'hE000), 0, 0, 0, 0, 0);
        step("t_pre", 1, W'(16'hE001), 0, 0, 0, 0, 0);
        step("t_pre", 0, '0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step("trip", 1, W'(16'hE002 + i), 1, 1, 0, 0, 0);
        chk("trip.data", fe_queue_o, W'(16'hE015));

        // Reset mid-stream with roll and deq
        step("r_yumi", 0, '0, 1, 0, 0, 0, 0);
        step("r_rst", 1, W'(8'h77), 1, 1, 1, 0, 1);
        chk("midrst.v", W'(fe_queue_v_o), W'(0));
        chk("midrst.ready", W'(fe_queue_ready_o), W'(1));
        chk("midrst.empty", W'(empty_o), W'(1));

        // Random legal traffic
        for (int i = 0; i < 400; i++) begin
            d  = {$urandom, $urandom};
            v  = ($urandom_range(0, 3) != 0);
            y  = (rd < mq.size()) && ($urandom_range(0, 2) != 0);
            dq = (rd > 0) && ($urandom_range(0, 2) == 0);
            rl = ($urandom_range(0, 19) == 0);
            cl = ($urandom_range(0, 39) == 0);
            step("rand", v, d, y, dq, rl, cl, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
